dtree_feature_loader: RTL

DTREE_FEATURE_LOADER -- requirements
Module: dtree_feature_loader

---
 rtl/dtree_pkg.sv | 15 +
 rtl/dtree_feature_loader.sv | 94 +++++++++
 2 files changed

// File: rtl/dtree_pkg.sv
// dtree_pkg: shared constants, FSM states and raw-index to feature-slot mapping for the feature loader.
package dtree_pkg;
  localparam int FEAT_W = 8;
  localparam int N_RAW = 20;
  localparam int N_FEAT = 18;
  localparam int SKIP_IDX [2] = '{4, 5};
  typedef enum logic [1:0] {COLLECT, SETTLE, HOLD} state_e;
  function automatic bit is_skip(input int raw_idx);
    return raw_idx == SKIP_IDX[0] || raw_idx == SKIP_IDX[1];
  endfunction
  // Raw indices above the skipped pair shift down by two slots.
  function automatic int slot_of(input int raw_idx);
    return raw_idx < SKIP_IDX[0] ? raw_idx : raw_idx - 2;
  endfunction
endpackage

// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: collects a raw feature frame, drives the classifier, captures its class after settling.
module dtree_feature_loader #(
  parameter int FEAT_W = dtree_pkg::FEAT_W,
  parameter int N_RAW = dtree_pkg::N_RAW,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [FEAT_W-1:0]                    s_data,
  input  logic                                 s_last,
  output logic [dtree_pkg::N_FEAT*FEAT_W-1:0]  feat_o,
  input  logic [1:0]                           cls_i,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [1:0]                           m_class,
  output logic                                 frame_err,
  output logic [15:0]                          frame_cnt
);
  import dtree_pkg::*;
  localparam int IW = $clog2(N_RAW);
  localparam int SW = $clog2(N_FEAT);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N_FEAT-1:0][FEAT_W-1:0] feat_q, feat_d;
  logic [3:0] cnt_q, cnt_d;
  logic m_valid_q, m_valid_d;
  logic [1:0] m_class_q, m_class_d;
  logic frame_err_q, frame_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic acc, at_end;
  // Gating with rst_n keeps s_ready low for the whole reset interval.
  assign s_ready = rst_n && state_q == COLLECT;
  assign acc = s_valid && s_ready;
  assign at_end = idx_q == IW'(N_RAW - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    feat_d = feat_q;
    cnt_d = cnt_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = acc && (s_last != at_end);
    if (acc) begin
      if (!is_skip(int'(idx_q))) feat_d[SW'(slot_of(int'(idx_q)))] = s_data;
      idx_d = (s_last || at_end) ? '0 : idx_q + 1'b1;
      if (s_last && at_end) begin
        state_d = SETTLE;
        cnt_d = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    if (state_q == SETTLE) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == 4'(SETTLE_CYCLES)) begin
        m_class_d = cls_i;
        m_valid_d = 1'b1;
        state_d = HOLD;
      end
    end
    if (state_q == HOLD && m_ready) begin
      m_valid_d = 1'b0;
      state_d = COLLECT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q <= '0;
      feat_q <= '0;
      cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      feat_q <= feat_d;
      cnt_q <= cnt_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign feat_o = feat_q;
  assign m_valid = m_valid_q;
  assign m_class = m_class_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
endmodule
